// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the register file write port: ALU/memory arbitration, FIFO, issue register.
// Optional forwarding lookup is compiled in with `define WB_FORWARD_EN.
module regfile_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_reg,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_reg,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     port_hold,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        write_reg,
    output logic [DATA_W-1:0]        write_data,
    input  logic [ADDR_W-1:0]        look_reg,
    output logic                     look_hit,
    output logic [DATA_W-1:0]        look_data,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] XZR = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0] fifo_reg  [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              not_full;
    logic              alu_fire;
    logic              mem_fire;
    logic              acc_store;
    logic [ADDR_W-1:0] acc_reg;
    logic [DATA_W-1:0] acc_data;
    logic              pop;
    logic              bypass;
    logic              push;

    assign not_full  = (count < CNT_W'(DEPTH));
    assign alu_ready = not_full;
    assign mem_ready = not_full && !alu_valid;
    assign pending   = count;

    // ALU has fixed priority; writes to XZR are accepted but never stored.
    assign alu_fire  = alu_valid && alu_ready;
    assign mem_fire  = mem_valid && mem_ready;
    assign acc_reg   = alu_fire ? alu_reg  : mem_reg;
    assign acc_data  = alu_fire ? alu_data : mem_data;
    assign acc_store = (alu_fire || mem_fire) && (acc_reg != XZR);

    assign pop    = !port_hold && (count != '0);
    assign bypass = !port_hold && (count == '0) && acc_store;
    assign push   = acc_store && !bypass;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= acc_reg;
            fifo_data[wr_ptr] <= acc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Issue register: FIFO head has precedence so a bypass never overtakes queued writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else if (pop) begin
            RegWrite   <= 1'b1;
            write_reg  <= fifo_reg[rd_ptr];
            write_data <= fifo_data[rd_ptr];
        end else if (bypass) begin
            RegWrite   <= 1'b1;
            write_reg  <= acc_reg;
            write_data <= acc_data;
        end else begin
            RegWrite   <= 1'b0;
        end
    end

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        look_hit  = 1'b0;
        look_data = '0;
        idx       = '0;
        if (look_reg != XZR) begin
            if (RegWrite && (write_reg == look_reg)) begin
                look_hit  = 1'b1;
                look_data = write_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PTR_W'(i);
                if ((CNT_W'(i) < count) && (fifo_reg[idx] == look_reg)) begin
                    look_hit  = 1'b1;
                    look_data = fifo_data[idx];
                end
            end
        end
    end
`else
    logic unused_look;
    assign unused_look = ^look_reg;
    assign look_hit    = 1'b0;
    assign look_data   = '0;
`endif

endmodule
